// File: rtl/ldl_fifo_pkg.sv
// Shared constants and helpers for the ldl synchronous FIFO controller.
package ldl_fifo_pkg;

  localparam int unsigned OBUF_DEPTH = 2;

  // Pointer increment that wraps from depth-1 back to 0; depth need not be a power of 2.
  function automatic int unsigned ptr_inc_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ldl_fifo_obuf.sv
// Two-entry first-word-fall-through output buffer. Entry e0 is always the head;
// words arriving on ld are appended behind any word already held.
module ldl_fifo_obuf
  import ldl_fifo_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] din,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic [1:0]    cnt
);

  logic [DW-1:0] e0, e1;
  logic          pop, take;

  assign pop       = pop_valid && pop_ready;
  // A full buffer can still take a word in the same cycle its head leaves.
  assign take      = ld && ((cnt < 2'(OBUF_DEPTH)) || pop);
  assign pop_valid = (cnt != 2'd0);
  assign pop_data  = e0;

  // NOTE: sequential state is assigned with <= only, so every register here sees the
  // pre-edge values of its neighbours and the shift e0 <= e1 is order-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      // NOTE: the data entries are reset as well because pop_data must read 0 after
      // reset; a large storage array would normally be left unreset.
      e0  <= '0;
      e1  <= '0;
    end else begin
      unique case ({pop, take})
        2'b10: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ldl_sfifo_ctrl_v1.sv
// Synchronous FIFO controller for an external registered-read RAM with a 2-entry FWFT
// output buffer. Define LDL_SFIFO_CHK_EN to enable the sticky read-valid protocol check on err.
module ldl_sfifo_ctrl_v1
  import ldl_fifo_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = $clog2(DEPTH + 3)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_din,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  input  logic          ram_rv,
  output logic [CW-1:0] count,
  output logic          err
);

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] ram_cnt;
  logic          inflight;
  logic [1:0]    obuf_cnt;
  logic          push_fire, pop_fire;
  logic [2:0]    occ;

  // Depends only on registered state (and rst), never on pop_ready.
  assign push_ready = !rst && (ram_cnt != CW'(DEPTH));
  assign push_fire  = push_valid && push_ready;

  assign ram_we  = push_fire;
  assign ram_wa  = wptr;
  assign ram_din = push_data;

  // Issue a read only if the buffer has a slot for it once this cycle's pop leaves.
  // ram_cnt excludes the word being written now, so rptr never equals a live wptr.
  assign pop_fire = pop_valid && pop_ready;
  assign occ      = {1'b0, obuf_cnt} + {2'b00, inflight};
  assign ram_re   = !rst && (ram_cnt != '0) && (occ < 3'(OBUF_DEPTH) + {2'b00, pop_fire});
  assign ram_ra   = rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push_fire) wptr <= AW'(ptr_inc_wrap(32'(wptr), DEPTH));
      if (ram_re)    rptr <= AW'(ptr_inc_wrap(32'(rptr), DEPTH));
      ram_cnt  <= ram_cnt + CW'(push_fire) - CW'(ram_re);
      inflight <= ram_re;
    end
  end

  assign count = ram_cnt + CW'(inflight) + CW'(obuf_cnt);

  ldl_fifo_obuf #(
    .DW(DW)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .ld       (ram_rv),
    .din      (ram_dout),
    .pop_valid(pop_valid),
    .pop_ready(pop_ready),
    .pop_data (pop_data),
    .cnt      (obuf_cnt)
  );

`ifdef LDL_SFIFO_CHK_EN
  logic err_q;

  // A read-valid must arrive exactly one cycle after each issued read.
  always_ff @(posedge clk) begin
    if (rst)                    err_q <= 1'b0;
    else if (inflight != ram_rv) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
